// File: rtl/coe_fetch_ctrl.sv
// Coefficient ROM fetch controller: requests the ROM, streams a run of words into a small
// FIFO and hands pairs downstream. Optional checksum output under COE_FETCH_CHECKSUM_EN.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_REQ   | rom_start asserted, waiting for coe_ready
// S_FETCH | issuing one address per cycle while credit exists
// S_DRAIN | all addresses issued, waiting for the last word to be accepted
module coe_fetch_ctrl #(
   parameter int ADDR_W     = 7,
   parameter int COE_W      = 7,
   parameter int FIFO_DEPTH = 4,
   parameter int ROM_LAT    = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [5:0]        num_words_i,
   output logic              rom_start_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [COE_W-1:0]  matrix_coe_1_i,
   input  logic [COE_W-1:0]  matrix_coe_2_i,
   input  logic              coe_ready_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [COE_W-1:0]  out_coe_1_o,
   output logic [COE_W-1:0]  out_coe_2_o,
   output logic              busy_o,
`ifdef COE_FETCH_CHECKSUM_EN
   output logic [15:0]       checksum_o,
`endif
   output logic              done_o
);

   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = PW + 1;
   localparam int PAIR_W = 2 * COE_W;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_FETCH, S_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d, addr_next;
   logic [5:0]          left_q, left_d;
   logic [ROM_LAT-1:0]  pipe_q, pipe_d;
   logic                done_q, done_d;
   logic [PAIR_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0]       wr_q, rd_q;
   logic [CW-1:0]       cnt_q;
   logic [7:0]          in_flight;
   logic                push, pop, credit, issue, start_acc;

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < ROM_LAT; i++) in_flight = in_flight + 8'(pipe_q[i]);
   end

   // Only the low 5 bits walk the 32-word ROM; the upper bits stay on the run's base page.
   assign addr_next   = {addr_q[ADDR_W-1:5], addr_q[4:0] + 5'd1};
   assign push        = pipe_q[ROM_LAT-1];
   assign out_valid_o = (cnt_q != '0);
   assign pop         = out_valid_o && out_ready_i;
   assign credit      = (8'(cnt_q) + in_flight) < 8'(FIFO_DEPTH);
   assign pipe_d      = ROM_LAT'({pipe_q, issue});

   assign rom_start_o = (state_q == S_REQ);
   assign busy_o      = (state_q != S_IDLE);
   assign rom_addr_o  = addr_q;
   assign done_o      = done_q;
   assign {out_coe_2_o, out_coe_1_o} = mem_q[rd_q];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      left_d    = left_q;
      issue     = 1'b0;
      done_d    = 1'b0;
      start_acc = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               addr_d    = base_addr_i;
               left_d    = num_words_i;
               if (num_words_i == 6'd0) done_d  = 1'b1;
               else if (coe_ready_i)    state_d = S_FETCH;
               else                     state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (coe_ready_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (credit) begin
               issue  = 1'b1;
               addr_d = addr_next;
               left_d = left_q - 6'd1;
               if (left_q == 6'd1) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Done lands the cycle after the pop that empties both the FIFO and the ROM pipe.
            if (pop && cnt_q == CW'(1) && in_flight == 8'd0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         left_q  <= '0;
         pipe_q  <= '0;
         done_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         left_q  <= left_d;
         pipe_q  <= pipe_d;
         done_q  <= done_d;
         if (push) begin
            mem_q[wr_q] <= {matrix_coe_2_i, matrix_coe_1_i};
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         if (push && !pop)      cnt_q <= cnt_q + 1'b1;
         else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      end
   end

`ifdef COE_FETCH_CHECKSUM_EN
   logic [15:0] checksum_q;
   always_ff @(posedge clk_i) begin
      if (reset_i)        checksum_q <= '0;
      else if (start_acc) checksum_q <= '0;
      else if (pop)       checksum_q <= checksum_q + 16'(mem_q[rd_q]);
   end
   assign checksum_o = checksum_q;
`endif

endmodule

// File: doc/coe_fetch_ctrl.md
Name: coe_fetch_ctrl

Overview:
- Requester side of the coefficient ROM interface: drives rom_start/rom_addr, waits for coe_ready, then streams a programmed run of ROM words.
- Each ROM word is a coefficient pair {matrix_coe_2, matrix_coe_1}. Pairs are buffered in a small FIFO and delivered to the matrix datapath over a valid/ready handshake.
- Sits between the coefficient ROM wrapper and the matrix multiply engine; absorbs downstream backpressure without dropping ROM data.

Parameters:
- ADDR_W, 7, ROM address width driven on rom_addr; ROM decodes low 5 bits (32 words).
- COE_W, 7, width of each coefficient.
- FIFO_DEPTH, 4, output buffer entries (power of 2, >=2).
- ROM_LAT, 1, cycles from rom_addr change to valid q.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a fetch run (ignored while busy)
- base_addr  in  ADDR_W  first ROM address of run, sampled on start
- num_words  in  6  words to fetch, 1..32; 0 = immediate done
- rom_start  out  1  request to ROM wrapper
- rom_addr  out  ADDR_W  ROM read address
- matrix_coe_1  in  COE_W  ROM q[6:0]
- matrix_coe_2  in  COE_W  ROM q[13:7]
- coe_ready  in  1  ROM wrapper ready (sticky once set)
- out_valid  out  1  out_coe_* valid
- out_ready  in  1  downstream accepts
- out_coe_1  out  COE_W  buffered coefficient 1
- out_coe_2  out  COE_W  buffered coefficient 2
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, last word accepted downstream

Behaviour:
- Reset (sync, active-high): state IDLE; rom_start=0, rom_addr=0, out_valid=0, out_coe_*=0, busy=0, done=0; FIFO emptied; in-flight pipe cleared. A reset asserted mid-run aborts the run; no done pulse.
- FSM:
  - IDLE: on start, latch base_addr/num_words.
    - num_words==0: pulse done next cycle, stay IDLE.
    - coe_ready already 1: go FETCH.
    - otherwise: go REQ.
  - REQ: rom_start=1 held until coe_ready seen high, then FETCH. rom_start is otherwise 0.
  - FETCH: issue one address per cycle while credit exists, credit = fifo_count + in_flight < FIFO_DEPTH. On each issue, rom_addr advances by 1. The low 5 bits wrap 31->0; upper bits hold base_addr[6:5]. After num_words issues, go DRAIN.
  - DRAIN: wait until all in-flight words have landed, the FIFO is empty and the final pop has occurred. Then pulse done, go IDLE.
- busy=1 in REQ/FETCH/DRAIN.
- In-flight tracking: ROM_LAT-deep valid shift register. A word issued at cycle t is pushed to the FIFO at t+ROM_LAT from {matrix_coe_2, matrix_coe_1}. Credit guarantees the push never overflows.
- FIFO:
  - Output is the registered head; out_valid = !empty.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - A push into an empty FIFO is visible on out_valid the next cycle.
- Throughput: 1 word/cycle with out_ready held high. First out_valid is 1+ROM_LAT cycles after entering FETCH.
- start while busy is ignored; latched parameters are unaffected.
- out_coe_* hold stable while out_valid && !out_ready.

Optional Feature:
- Macro: COE_FETCH_CHECKSUM_EN.
  - Defined: adds output port checksum [15:0]. It is cleared on start and accumulates the zero-extended sum of {out_coe_2,out_coe_1} for every accepted word, modulo 2^16. It is valid and stable from the done pulse until the next start.
  - Undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset mid-FETCH (base 0, num 8, reset after 3 issues) -> next cycle busy=0, out_valid=0, rom_start=0, no done; a following start runs cleanly.
- coe_ready low at start, raised 5 cycles later -> rom_start high for those 5 cycles; first rom_addr issue the cycle after coe_ready=1.
- base_addr=0x04, num_words=4, out_ready=1, ROM word n = {n, n+1} -> out pairs (coe_2,coe_1) = (4,5),(5,6),(6,7),(7,8) on consecutive cycles; done 1 cycle after last pop.
- base_addr=0x1E, num_words=4 -> rom_addr sequence 0x1E,0x1F,0x00,0x01; 4 words delivered in that order.
- num_words=16, out_ready toggled 1 cycle high / 3 cycles low -> no word lost or duplicated; fifo_count never >4; rom_addr stalls when credit exhausted.
- num_words=0 -> done pulse next cycle, rom_start and out_valid never asserted.
- Checksum (COE_FETCH_CHECKSUM_EN): base 0, num 3, words 0x0001,0x0002,0x3FFF -> checksum=0x4002 at done.
